// File: rtl/sync_fifo_param_pkg.sv
// Shared defaults and the parameter-legality check for the synchronous FIFO.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_AF_THRESH = 12;
  localparam int DEF_AE_THRESH = 4;

  // Depth must be a power of two so pointers wrap naturally at 2*DEPTH.
  function automatic bit params_ok(input int width, input int depth, input int addr_w,
                                   input int af, input int ae);
    return (width >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (addr_w == $clog2(depth)) && (af >= 1) && (af <= depth - 1) &&
           (ae >= 0) && (ae <= depth - 2);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// FIFO bus: master drives requests and write data, slave (the FIFO) drives data and status.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              clr;
  logic              we;
  logic [WIDTH-1:0]  data_in;
  logic              re;
  logic [WIDTH-1:0]  data_out;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, we, data_in, re,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  clr, we, data_in, re,
    output data_out, rd_valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param_ram_dp_sync.sv
// WIDTH x DEPTH single-clock dual-port RAM; one write port, one registered read port.
// Read data appears one cycle after re_i and holds while re_i is low; storage is never reset.
module ram_dp_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  data_in_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  data_out_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] data_out_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= data_in_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q <= '0;
    end else if (re_i) begin
      data_out_q <= mem_q[raddr_i];
    end
  end

  assign data_out_o = data_out_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO: pointers, occupancy, registered flags and error pulses
// around ram_dp_sync. One-cycle read latency; writes while full / reads while empty are dropped.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AF_THRESH = DEF_AF_THRESH,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_param_if.slave   bus
);

  if (!params_ok(WIDTH, DEPTH, ADDR_W, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("sync_fifo_param: illegal WIDTH/DEPTH/ADDR_W/threshold parameters");
  end

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_C    = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C    = AE_THRESH[ADDR_W:0];

  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic             full_q, empty_q, afull_q, aempty_q;
  logic             rd_valid_q, overflow_q, underflow_q;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] rd_data;

  // Accept decisions use registered flags only, so simultaneous we&re on an empty FIFO never falls through.
  assign wr_acc = bus.we & ~full_q  & ~bus.clr;
  assign rd_acc = bus.re & ~empty_q & ~bus.clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(wr_acc);
      rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(rd_acc);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == DEPTH_C);
      empty_q     <= (count_d == '0);
      afull_q     <= (count_d >= AF_C);
      aempty_q    <= (count_d <= AE_C);
      rd_valid_q  <= rd_acc;
      overflow_q  <= bus.we & full_q  & ~bus.clr;
      underflow_q <= bus.re & empty_q & ~bus.clr;
    end
  end

  ram_dp_sync #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk        (clk),
    .rst        (rst),
    .we_i       (wr_acc),
    .waddr_i    (wr_ptr_q[ADDR_W-1:0]),
    .data_in_i  (bus.data_in),
    .re_i       (rd_acc),
    .raddr_i    (rd_ptr_q[ADDR_W-1:0]),
    .data_out_o (rd_data)
  );

  assign bus.data_out     = rd_data;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  // The wrap bit makes the pointer distance equal occupancy even when full.
  a_ptr_count : assert property (@(posedge clk) disable iff (rst)
    (wr_ptr_q - rd_ptr_q) == count_q);

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int AF     = 12;
  localparam int AE     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) fi ();

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (fi.slave)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout;
  bit               m_rdv, m_ovf, m_udf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_rdv  = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // Drive one cycle of requests and advance the model by the same rules.
  task automatic step(input bit w, input bit r, input bit c, input logic [WIDTH-1:0] d);
    bit was_full, was_empty;
    fi.we = w; fi.re = r; fi.clr = c; fi.data_in = d;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (c) begin
      q.delete();
      m_rdv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      m_ovf = w && was_full;
      m_udf = r && was_empty;
      m_rdv = r && !was_empty;
      if (m_rdv) m_dout = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("count",        fi.count,        q.size());
      chk("full",         fi.full,         q.size() == DEPTH);
      chk("empty",        fi.empty,        q.size() == 0);
      chk("almost_full",  fi.almost_full,  q.size() >= AF);
      chk("almost_empty", fi.almost_empty, q.size() <= AE);
      chk("overflow",     fi.overflow,     m_ovf);
      chk("underflow",    fi.underflow,    m_udf);
      chk("rd_valid",     fi.rd_valid,     m_rdv);
      chk("data_out",     fi.data_out,     m_dout);
    end
  end

  initial begin
    fi.we = 1'b0; fi.re = 1'b0; fi.clr = 1'b0; fi.data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    step(0, 0, 0, 8'h00);
    chk("rst_empty", fi.empty, 1);
    chk("rst_aempty", fi.almost_empty, 1);
    chk("rst_count", fi.count, 0);
    chk("rst_full", fi.full, 0);
    chk("rst_dout", fi.data_out, 8'h00);
    chk("rst_rdv", fi.rd_valid, 0);

    // Asynchronous reset mid-run after 5 writes
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h60 + i));
    chk("pre_rst_count", fi.count, 5);
    rst = 1'b1;
    model_reset();
    #2;
    chk("async_rst_count", fi.count, 0);
    chk("async_rst_empty", fi.empty, 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Fill to full, almost_full from the 12th write
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, 8'(8'h10 + i));
      chk("fill_afull", fi.almost_full, (i + 1) >= 12);
    end
    chk("fill_count", fi.count, 16);
    chk("fill_full", fi.full, 1);
    step(1, 0, 0, 8'hEE);
    chk("ovf_pulse", fi.overflow, 1);
    chk("ovf_count", fi.count, 16);
    step(0, 0, 0, 8'h00);
    chk("ovf_gone", fi.overflow, 0);

    // Drain in order
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 0, 8'h00);
      chk("drain_data", fi.data_out, 8'h10 + i);
      chk("drain_rdv", fi.rd_valid, 1);
    end
    chk("drain_empty", fi.empty, 1);

    // Underflow
    step(0, 1, 0, 8'h00);
    chk("udf_pulse", fi.underflow, 1);
    chk("udf_rdv", fi.rd_valid, 0);
    chk("udf_dout", fi.data_out, 8'h1F);
    step(0, 0, 0, 8'h00);
    chk("udf_gone", fi.underflow, 0);

    // Pointer wrap
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) step(1, 0, 0, 8'($urandom));
      for (int i = 0; i < 10; i++) step(0, 1, 0, 8'h00);
      chk("wrap_count", fi.count, 0);
    end

    // Simultaneous we&re at 5, 16 and 0
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h40 + i));
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 8'(8'h50 + i));
      chk("sim5_count", fi.count, 5);
      chk("sim5_data", fi.data_out, 8'h40 + i);
    end
    for (int i = 0; i < 11; i++) step(1, 0, 0, 8'($urandom));
    chk("sim16_pre", fi.count, 16);
    step(1, 1, 0, 8'hCC);
    chk("sim16_ovf", fi.overflow, 1);
    chk("sim16_count", fi.count, 15);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 8'h00);
    step(1, 1, 0, 8'h77);
    chk("sim0_udf", fi.underflow, 1);
    chk("sim0_count", fi.count, 1);
    step(0, 1, 0, 8'h00);
    chk("sim0_data", fi.data_out, 8'h77);

    // Flush with we&re in the same cycle
    for (int i = 0; i < 9; i++) step(1, 0, 0, 8'(8'h80 + i));
    step(1, 1, 1, 8'h99);
    chk("clr_count", fi.count, 0);
    chk("clr_empty", fi.empty, 1);
    chk("clr_ovf", fi.overflow, 0);
    chk("clr_udf", fi.underflow, 0);
    chk("clr_rdv", fi.rd_valid, 0);
    chk("clr_dout", fi.data_out, 8'h77);
    step(1, 0, 0, 8'hA5);
    step(0, 1, 0, 8'h00);
    chk("post_clr_data", fi.data_out, 8'hA5);

    // Random traffic with alternating fill/drain bias
    for (int n = 0; n < 1600; n++) begin
      int wb;
      wb = ((n / 200) % 2 == 0) ? 70 : 30;
      step($urandom_range(0, 99) < wb, $urandom_range(0, 99) < (100 - wb),
           $urandom_range(0, 99) < 2, 8'($urandom));
    end

    step(0, 0, 0, 8'h00);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
